pid_loop_scheduler: RTL
=======================

Name: pid_loop_scheduler

Overview:
Time-multiplexes one signed multiply-accumulate path across NCH PID control channels. It sits between the AXI4-Lite register bank, which supplies gains, the enable mask and setpoints, and the actuator outputs. Each sample_tick starts one frame that computes every enabled channel in ascending order. Results are emitted as one-cycle pulses tagged with the channel number.

Parameters:
NCH, 4, number of channels (2..16)
DW, 16, signed width of setpoint and feedback
CW, 16, signed coefficient width, fixed point with FRAC fractional bits
FRAC, 8, fractional bits of kp/ki/kd
IW, 24, signed integrator width
OW, 16, signed output width

Ports:
ACLK  in  1  clock
ARESET  in  1  synchronous reset, active-high
sample_tick  in  1  frame start pulse
cfg_kp  in  CW  proportional gain
cfg_ki  in  CW  integral gain
cfg_kd  in  CW  derivative gain
cfg_en  in  NCH  per-channel enable mask
sp  in  NCH*DW  setpoints, channel c at [c*DW +: DW]
fb  in  NCH*DW  feedback values, same packing
clr_overrun  in  1  clears the overrun flag
busy  out  1  high whenever the FSM is not IDLE
out_valid  out  1  one-cycle result strobe
out_ch  out  clog2(NCH)  channel index of out_data
out_data  out  OW  saturated PID output
overrun  out  1  sticky; set by a tick that arrives while busy

Behaviour:
- Clock and reset: single clock ACLK; ARESET is synchronous and active-high.
- Reset values: FSM=IDLE, ch=0. All integ[c] and e_prev[c]=0. busy, out_valid, out_ch, out_data and overrun = 0. Reset mid-frame aborts the frame, and no further out_valid is produced.
- Tick acceptance: in IDLE, sample_tick latches cfg_kp/ki/kd and cfg_en into shadow registers for the whole frame. It then sets ch=0 and moves to SCAN.
- Tick while busy: a tick in any state other than IDLE is ignored and sets overrun. This includes the OUT cycle of the last channel.
- overrun priority: if overrun is set and clr_overrun arrives in the same cycle, set wins.
- FSM states and transitions:
  - SCAN: if en[ch]=1, go to ERR. Otherwise clear integ[ch] and e_prev[ch]; then go to IDLE if ch=NCH-1, else increment ch and stay in SCAN. A disabled channel costs 1 cycle.
  - ERR: sample sp[ch] and fb[ch] in this cycle, not at the tick.
    - e = sp - fb, DW+1 bits.
    - d = e - e_prev[ch], DW+2 bits.
    - integ[ch] = sat_IW(integ[ch] + e), clamped to [-(2^(IW-1)), 2^(IW-1)-1]. This clamp is the anti-windup.
    - e and d are registered.
  - MP: acc = kp*e.
  - MI: acc = acc + ki*integ[ch], using the updated integrator.
  - MD: acc = acc + kd*d.
  - OUT: out_valid=1, out_ch=ch, out_data=sat_OW(acc >>> FRAC) (arithmetic shift, truncation toward -inf). Also e_prev[ch]=e. Then go to IDLE if ch=NCH-1, else increment ch and go to SCAN.
- Multiplier sharing: exactly one multiplier is in use per cycle, in MP, MI or MD.
- Accumulator width: CW+IW+2 bits, so it never overflows.
- Timing: an enabled channel costs 6 cycles (SCAN, ERR, MP, MI, MD, OUT). For a tick at cycle T with ch0 enabled, out_valid occurs at T+6.
- Output hold: out_ch and out_data hold between strobes; out_valid is low outside OUT.
- Frame end: busy drops in the cycle the FSM returns to IDLE. A new tick is accepted from that cycle on.
- Empty frame: cfg_en=0 gives a frame of NCH SCAN cycles, no outputs, and clears all channel state.
- Coefficients: changes to cfg_* during a frame take effect on the next frame.

Test Plan:
1. Proportional: kp=0x0100, ki=kd=0, en=0001, sp0=100, fb0=40, tick at T -> out_valid at T+6, out_ch=0, out_data=60, busy low at T+7.
2. Integral: kp=kd=0, ki=0x0080, e=10, three ticks spaced 20 cycles apart -> outputs 5, 10, 15. Then en0=0 for one frame and re-enable -> next output 5.
3. Derivative: kp=ki=0, kd=0x0100, e=10 for two frames -> outputs 10 then 0. Then e=-6 -> output -16.
4. Saturation: kp=0x7FFF, sp=30000, fb=0 -> out_data=32767. Swap sp and fb -> -32768. Integrator held at 2^23-1 when e>0 is sustained.
5. Mask and ordering: en=1010, kp=0x0100, e1=7, e3=-3, tick at T -> (ch1, 7) at T+7, (ch3, -3) at T+14, busy low at T+15, no strobe for ch0 or ch2.
6. Overrun and reset: tick at T+3 during a frame -> ignored, overrun=1. clr_overrun together with a new busy tick -> overrun stays 1; clr alone -> 0. ARESET at T+4 -> no out_valid, all outputs 0, integ and e_prev cleared (verified via test 2 restarting at 5).

Source files
------------

// File: rtl/pid_loop_scheduler.sv
// pid_loop_scheduler: one shared signed MAC time-multiplexed over NCH PID channels.
// Each sample_tick runs one frame over the enabled channels in ascending order;
// every enabled channel produces one tagged, saturated out_valid pulse.
module pid_loop_scheduler #(
    parameter int NCH  = 4,
    parameter int DW   = 16,
    parameter int CW   = 16,
    parameter int FRAC = 8,
    parameter int IW   = 24,
    parameter int OW   = 16
) (
    input  logic                     ACLK,
    input  logic                     ARESET,
    input  logic                     sample_tick,
    input  logic [CW-1:0]            cfg_kp,
    input  logic [CW-1:0]            cfg_ki,
    input  logic [CW-1:0]            cfg_kd,
    input  logic [NCH-1:0]           cfg_en,
    input  logic [NCH*DW-1:0]        sp,
    input  logic [NCH*DW-1:0]        fb,
    input  logic                     clr_overrun,
    output logic                     busy,
    output logic                     out_valid,
    output logic [$clog2(NCH)-1:0]   out_ch,
    output logic [OW-1:0]            out_data,
    output logic                     overrun
);
    localparam int CHW = $clog2(NCH);
    // Widest multiplier operand: integrator or the DW+2 bit derivative.
    localparam int BW  = (IW > DW + 2) ? IW : DW + 2;
    // Accumulator holds three full-width products without overflow.
    localparam int AW  = CW + BW + 2;
    localparam logic [CHW-1:0] LAST = CHW'(NCH - 1);

    typedef enum logic [2:0] {IDLE, SCAN, ERR, MP, MI, MD, OUT} state_t;
    state_t state, nxt;

    logic [CHW-1:0]        ch;
    logic signed [CW-1:0]  kp_s, ki_s, kd_s;
    logic [NCH-1:0]        en_s;
    logic signed [IW-1:0]  integ  [NCH];
    logic signed [DW:0]    e_prev [NCH];
    logic signed [DW:0]    e_r;
    logic signed [DW+1:0]  d_r;
    logic signed [AW-1:0]  acc;

    logic                  last;
    logic [DW-1:0]         sp_c, fb_c;
    logic signed [DW:0]    e_now;
    logic signed [DW+1:0]  d_now;
    logic signed [IW:0]    isum;
    logic signed [IW-1:0]  isat;
    logic signed [CW-1:0]  coef;
    logic signed [BW-1:0]  opnd;
    logic signed [CW+BW-1:0] prod;
    logic signed [AW-1:0]  acc_sum, sh;
    logic [OW-1:0]         osat;

    assign last = (ch == LAST);

    // State register
    always_ff @(posedge ACLK) begin
        if (ARESET) state <= IDLE;
        else        state <= nxt;
    end

    // Next-state logic: disabled channels cost one SCAN cycle, enabled ones six
    always_comb begin
        nxt = state;
        case (state)
            IDLE: if (sample_tick) nxt = SCAN;
            SCAN: if (en_s[ch]) nxt = ERR;
                  else if (last) nxt = IDLE;
            ERR:  nxt = MP;
            MP:   nxt = MI;
            MI:   nxt = MD;
            MD:   nxt = OUT;
            OUT:  nxt = last ? IDLE : SCAN;
            default: nxt = IDLE;
        endcase
    end

    // Moore outputs
    always_comb begin
        busy      = (state != IDLE);
        out_valid = (state == OUT);
    end

    // Error, derivative and anti-windup integrator update for the current channel
    always_comb begin
        sp_c  = sp[ch*DW +: DW];
        fb_c  = fb[ch*DW +: DW];
        e_now = {sp_c[DW-1], sp_c} - {fb_c[DW-1], fb_c};
        d_now = {e_now[DW], e_now} - {e_prev[ch][DW], e_prev[ch]};
        isum  = {integ[ch][IW-1], integ[ch]} + {{(IW-DW){e_now[DW]}}, e_now};
        if (isum[IW] != isum[IW-1])
            isat = isum[IW] ? {1'b1, {(IW-1){1'b0}}} : {1'b0, {(IW-1){1'b1}}};
        else
            isat = isum[IW-1:0];
    end

    // Single shared multiplier: operand pair chosen by the MAC phase
    always_comb begin
        coef = kp_s;
        opnd = BW'(e_r);
        case (state)
            MI: begin coef = ki_s; opnd = BW'(integ[ch]); end
            MD: begin coef = kd_s; opnd = BW'(d_r);       end
            default: ;
        endcase
        prod    = coef * opnd;
        acc_sum = acc + AW'(prod);
        sh      = acc_sum >>> FRAC;
        if (&sh[AW-1:OW-1] || ~|sh[AW-1:OW-1])
            osat = sh[OW-1:0];
        else
            osat = sh[AW-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
    end

    // Datapath: shadow config, channel pointer, per-channel state, MAC and result regs
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            ch       <= '0;
            kp_s     <= '0;
            ki_s     <= '0;
            kd_s     <= '0;
            en_s     <= '0;
            e_r      <= '0;
            d_r      <= '0;
            acc      <= '0;
            out_ch   <= '0;
            out_data <= '0;
            for (int i = 0; i < NCH; i++) begin
                integ[i]  <= '0;
                e_prev[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: if (sample_tick) begin
                    kp_s <= cfg_kp;
                    ki_s <= cfg_ki;
                    kd_s <= cfg_kd;
                    en_s <= cfg_en;
                    ch   <= '0;
                end
                SCAN: if (!en_s[ch]) begin
                    integ[ch]  <= '0;
                    e_prev[ch] <= '0;
                    if (!last) ch <= ch + 1'b1;
                end
                ERR: begin
                    e_r       <= e_now;
                    d_r       <= d_now;
                    integ[ch] <= isat;
                end
                MP: acc <= AW'(prod);
                MI: acc <= acc_sum;
                MD: begin
                    out_ch   <= ch;
                    out_data <= osat;
                end
                OUT: begin
                    e_prev[ch] <= e_r;
                    if (!last) ch <= ch + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Sticky overrun: a tick outside IDLE sets it and beats a simultaneous clear
    always_ff @(posedge ACLK) begin
        if (ARESET)                           overrun <= 1'b0;
        else if (sample_tick && state != IDLE) overrun <= 1'b1;
        else if (clr_overrun)                 overrun <= 1'b0;
    end
endmodule
